dispatch_unit: RTL and testbench

- Write-side partner of the issue queue.
- Accepts up to two decoded instructions per cycle from decode, tags each with a monotonically increasing instruction id, and buffers them in a small in-order staging FIFO.
- Drives push0/push1 into the issue queue, gated by the queue's free-slot count.
- Preserves program order: lane 0 is always older than lane 1.

---
 rtl/dispatch_unit_pkg.sv | 23 ++
 rtl/dispatch_unit_if.sv | 42 ++++
 rtl/dispatch_fifo.sv | 61 ++++++
 rtl/dispatch_unit.sv | 77 +++++++
 tb/tb_dispatch_unit.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/dispatch_unit_pkg.sv
// Shared widths and the staged-entry layout for the dispatch stage that
// feeds the issue queue.
package dispatch_unit_pkg;

    localparam int INST_WIDTH          = 32;
    localparam int PC_WIDTH            = 32;
    localparam int ID_WIDTH            = 8;
    localparam int NUM_IQ_ENTRIES      = 8;
    localparam int NUM_IQ_ENTRIES_LOG2 = 3;
    localparam int FREE_WIDTH          = NUM_IQ_ENTRIES_LOG2 + 1;

    typedef struct packed {
        logic [INST_WIDTH-1:0] instruction;
        logic [PC_WIDTH-1:0]   pc;
        logic [ID_WIDTH-1:0]   id;
    } entry_t;

    // Lane b only ever fires together with lane a, so this is the lane count 0..2.
    function automatic logic [1:0] lane_count(input logic a, input logic b);
        return {a & b, a ^ b};
    endfunction

endpackage

// File: rtl/dispatch_unit_if.sv
// Decode-side and issue-queue-side signals of the dispatch stage.
interface dispatch_unit_if;
    import dispatch_unit_pkg::*;

    logic                  in_valid0;
    logic [INST_WIDTH-1:0] in_instruction0;
    logic [PC_WIDTH-1:0]   in_pc0;
    logic                  in_valid1;
    logic [INST_WIDTH-1:0] in_instruction1;
    logic [PC_WIDTH-1:0]   in_pc1;
    logic                  in_ready;
    logic [FREE_WIDTH-1:0] free;
    logic                  push0;
    logic [INST_WIDTH-1:0] push_instruction0;
    logic [PC_WIDTH-1:0]   push_pc0;
    logic [ID_WIDTH-1:0]   push_id0;
    logic                  push1;
    logic [INST_WIDTH-1:0] push_instruction1;
    logic [PC_WIDTH-1:0]   push_pc1;
    logic [ID_WIDTH-1:0]   push_id1;

    // Environment side: decode lanes and the issue queue free count.
    modport master (
        output in_valid0, in_instruction0, in_pc0,
        output in_valid1, in_instruction1, in_pc1,
        output free,
        input  in_ready,
        input  push0, push_instruction0, push_pc0, push_id0,
        input  push1, push_instruction1, push_pc1, push_id1
    );

    // Dispatch side.
    modport slave (
        input  in_valid0, in_instruction0, in_pc0,
        input  in_valid1, in_instruction1, in_pc1,
        input  free,
        output in_ready,
        output push0, push_instruction0, push_pc0, push_id0,
        output push1, push_instruction1, push_pc1, push_id1
    );

endinterface

// File: rtl/dispatch_fifo.sv
// In-order staging FIFO: up to two writes at the tail and two reads at the
// head per cycle, with an occupancy count.
module dispatch_fifo
    import dispatch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic [1:0]             wr_n,
    input  entry_t                 wr_data0,
    input  entry_t                 wr_data1,
    input  logic [1:0]             rd_n,
    output entry_t                 rd_data0,
    output entry_t                 rd_data1,
    output logic [$clog2(DEPTH):0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] head1;
    logic [PTR_W-1:0] tail1;

    assign head1 = head + PTR_W'(1);
    assign tail1 = tail + PTR_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (clr) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(rd_n);
            tail  <= tail + PTR_W'(wr_n);
            count <= count + CNT_W'(wr_n) - CNT_W'(rd_n);
        end
    end

    // Storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (wr_n != 2'd0) mem[tail]  <= wr_data0;
        if (wr_n == 2'd2) mem[tail1] <= wr_data1;
    end

    always_comb begin
        rd_data0 = '0;
        rd_data1 = '0;
        if (count >= CNT_W'(1)) rd_data0 = mem[head];
        if (count >= CNT_W'(2)) rd_data1 = mem[head1];
    end

endmodule

// File: rtl/dispatch_unit.sv
// Dispatch stage: tags decoded instruction pairs with ids, stages them in
// program order and pushes them into the issue queue as free slots allow.
module dispatch_unit
    import dispatch_unit_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    dispatch_unit_if.slave   bus
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic [CNT_W-1:0]    count;
    logic [ID_WIDTH-1:0] next_id;
    logic                in_ready;
    logic                accept0;
    logic                accept1;
    logic                push0;
    logic                push1;
    logic [1:0]          wr_n;
    logic [1:0]          rd_n;
    entry_t              wr_data0;
    entry_t              wr_data1;
    entry_t              rd_data0;
    entry_t              rd_data1;

    // Room for a full pair is judged on registered occupancy only, so
    // in_ready never depends on the issue queue's free count.
    assign in_ready = (count <= CNT_W'(DEPTH - 2));
    assign accept0  = bus.in_valid0 && in_ready && !flush;
    assign accept1  = accept0 && bus.in_valid1;

    assign push0 = !flush && (count >= CNT_W'(1)) && (bus.free >= FREE_WIDTH'(1));
    assign push1 = !flush && (count >= CNT_W'(2)) && (bus.free >= FREE_WIDTH'(2));

    assign wr_n = lane_count(accept0, accept1);
    assign rd_n = lane_count(push0, push1);

    assign wr_data0 = '{instruction: bus.in_instruction0, pc: bus.in_pc0, id: next_id};
    assign wr_data1 = '{instruction: bus.in_instruction1, pc: bus.in_pc1,
                        id: next_id + ID_WIDTH'(1)};

    // The id counter survives flushes so ids stay unique in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) next_id <= '0;
        else        next_id <= next_id + ID_WIDTH'(wr_n);
    end

    dispatch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (flush),
        .wr_n     (wr_n),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1),
        .rd_n     (rd_n),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .count    (count)
    );

    assign bus.in_ready          = in_ready;
    assign bus.push0             = push0;
    assign bus.push_instruction0 = rd_data0.instruction;
    assign bus.push_pc0          = rd_data0.pc;
    assign bus.push_id0          = rd_data0.id;
    assign bus.push1             = push1;
    assign bus.push_instruction1 = rd_data1.instruction;
    assign bus.push_pc1          = rd_data1.pc;
    assign bus.push_id1          = rd_data1.id;

endmodule

// File: tb/tb_dispatch_unit.sv
// Directed bench for dispatch_unit: hand-computed expectations checked with
// immediate assertions.
module tb_dispatch_unit;
    import dispatch_unit_pkg::*;

    logic clk;
    logic rst_n;
    logic flush;
    int   total;
    int   bad;

    dispatch_unit_if bus ();

    dispatch_unit #(.DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stimulus must never raise lane 1 alone.
    always @(negedge clk) begin
        if (rst_n && bus.in_valid1 && !bus.in_valid0) begin
            bad++;
            $error("FAIL protocol in_valid1 observed=1 with in_valid0 required=1");
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v0, input logic [31:0] pc0,
                         input logic v1, input logic [31:0] pc1,
                         input logic [3:0] fr, input logic fl);
        bus.in_valid0       = v0;
        bus.in_pc0          = pc0;
        bus.in_instruction0 = 32'h1000_0000 | pc0;
        bus.in_valid1       = v1;
        bus.in_pc1          = pc1;
        bus.in_instruction1 = 32'h1000_0000 | pc1;
        bus.free            = fr;
        flush               = fl;
        #1;
    endtask

    task automatic idle(input logic [3:0] fr);
        drive(1'b0, 32'h0, 1'b0, 32'h0, fr, 1'b0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        idle(4'd8);
        #1;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_push0", bus.push0, 0);
        check("rst_push1", bus.push1, 0);
        check("rst_pc0", bus.push_pc0, 0);
        check("rst_id1", bus.push_id1, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [7:0] exp_id;

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b1;
        flush = 1'b0;
        idle(4'd0);

        // Single lane-0 instruction
        do_reset();
        drive(1'b1, 32'h100, 1'b0, 32'h0, 4'd8, 1'b0);
        check("single_in_ready", bus.in_ready, 1);
        check("single_no_push_yet", bus.push0, 0);
        tick();
        idle(4'd8);
        check("single_push0", bus.push0, 1);
        check("single_id0", bus.push_id0, 0);
        check("single_pc0", bus.push_pc0, 32'h100);
        check("single_instr0", bus.push_instruction0, 32'h1000_0100);
        check("single_push1", bus.push1, 0);
        tick();
        check("single_drained", bus.push0, 0);

        // Pair with plenty of free slots
        do_reset();
        drive(1'b1, 32'h200, 1'b1, 32'h204, 4'd8, 1'b0);
        tick();
        idle(4'd8);
        check("pair_push0", bus.push0, 1);
        check("pair_push1", bus.push1, 1);
        check("pair_id0", bus.push_id0, 0);
        check("pair_id1", bus.push_id1, 1);
        check("pair_pc0", bus.push_pc0, 32'h200);
        check("pair_pc1", bus.push_pc1, 32'h204);
        tick();
        check("pair_empty_push0", bus.push0, 0);
        check("pair_empty_ready", bus.in_ready, 1);

        // Fill with free = 0 (next_id = 2), then drain one per cycle
        drive(1'b1, 32'h300, 1'b1, 32'h304, 4'd0, 1'b0);
        check("fill_ready_c0", bus.in_ready, 1);
        tick();
        drive(1'b1, 32'h308, 1'b1, 32'h30C, 4'd0, 1'b0);
        check("fill_ready_c2", bus.in_ready, 1);
        check("fill_no_push_c2", bus.push0, 0);
        tick();
        drive(1'b1, 32'h310, 1'b1, 32'h314, 4'd0, 1'b0);
        check("full_ready", bus.in_ready, 0);
        check("full_push0", bus.push0, 0);
        check("full_push1", bus.push1, 0);
        tick();
        idle(4'd1);
        check("full_ready_hold", bus.in_ready, 0);
        check("drain_a_push0", bus.push0, 1);
        check("drain_a_push1", bus.push1, 0);
        check("drain_a_id", bus.push_id0, 2);
        check("drain_a_pc", bus.push_pc0, 32'h300);
        tick();
        check("drain_b_id", bus.push_id0, 3);
        check("drain_b_pc", bus.push_pc0, 32'h304);
        check("drain_b_ready", bus.in_ready, 0);
        tick();
        check("drain_c_id", bus.push_id0, 4);
        check("drain_c_pc", bus.push_pc0, 32'h308);
        check("drain_c_ready", bus.in_ready, 1);
        tick();
        check("drain_d_id", bus.push_id0, 5);
        check("drain_d_pc", bus.push_pc0, 32'h30C);
        check("drain_d_push1", bus.push1, 0);
        tick();
        check("drain_empty", bus.push0, 0);

        // Partial drain with a pair staged and free = 1
        do_reset();
        drive(1'b1, 32'h400, 1'b1, 32'h404, 4'd1, 1'b0);
        tick();
        idle(4'd1);
        check("partial_push0", bus.push0, 1);
        check("partial_push1", bus.push1, 0);
        check("partial_id0", bus.push_id0, 0);
        tick();
        check("partial_next_push0", bus.push0, 1);
        check("partial_next_id0", bus.push_id0, 1);
        check("partial_next_pc0", bus.push_pc0, 32'h404);
        tick();
        check("partial_empty", bus.push0, 0);

        // Build count = 3 with next_id = 7, then flush
        do_reset();
        drive(1'b1, 32'h500, 1'b1, 32'h504, 4'd8, 1'b0);
        tick();
        drive(1'b1, 32'h508, 1'b1, 32'h50C, 4'd8, 1'b0);
        check("stream_b_id0", bus.push_id0, 0);
        check("stream_b_id1", bus.push_id1, 1);
        tick();
        drive(1'b1, 32'h510, 1'b1, 32'h514, 4'd8, 1'b0);
        check("stream_c_id0", bus.push_id0, 2);
        check("stream_c_pc1", bus.push_pc1, 32'h50C);
        tick();
        drive(1'b1, 32'h518, 1'b0, 32'h0, 4'd0, 1'b0);
        tick();
        drive(1'b1, 32'h5F0, 1'b1, 32'h5F4, 4'd8, 1'b1);
        check("flush_ready_before", bus.in_ready, 0);
        check("flush_push0", bus.push0, 0);
        check("flush_push1", bus.push1, 0);
        tick();
        idle(4'd8);
        check("post_flush_push0", bus.push0, 0);
        check("post_flush_ready", bus.in_ready, 1);
        drive(1'b1, 32'h600, 1'b0, 32'h0, 4'd8, 1'b0);
        tick();
        idle(4'd8);
        check("post_flush_id", bus.push_id0, 7);
        check("post_flush_pc", bus.push_pc0, 32'h600);
        check("post_flush_push", bus.push0, 1);
        tick();

        // 300 single instructions with id wrap (next_id = 8)
        exp_id = 8'd8;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 32'h1000 + 32'(i) * 4, 1'b0, 32'h0, 4'd8, 1'b0);
            if (i > 0) begin
                check("wrap_push0", bus.push0, 1);
                check("wrap_id", bus.push_id0, exp_id);
                check("wrap_pc", bus.push_pc0, 32'h1000 + 32'(i - 1) * 4);
                exp_id = exp_id + 8'd1;
            end
            tick();
        end
        idle(4'd8);
        check("wrap_last_id", bus.push_id0, 8'd51);
        check("wrap_last_pc", bus.push_pc0, 32'h1000 + 32'd299 * 4);
        tick();
        check("wrap_empty", bus.push0, 0);

        // Asynchronous reset mid-cycle discards staged entries
        drive(1'b1, 32'h700, 1'b1, 32'h704, 4'd0, 1'b0);
        tick();
        idle(4'd8);
        check("pre_areset_push0", bus.push0, 1);
        check("pre_areset_push1", bus.push1, 1);
        rst_n = 1'b0;
        #1;
        check("areset_push0", bus.push0, 0);
        check("areset_push1", bus.push1, 0);
        check("areset_ready", bus.in_ready, 1);
        check("areset_pc0", bus.push_pc0, 0);
        check("areset_instr0", bus.push_instruction0, 0);
        tick();
        rst_n = 1'b1;
        drive(1'b1, 32'h800, 1'b0, 32'h0, 4'd8, 1'b0);
        tick();
        idle(4'd8);
        check("after_areset_id", bus.push_id0, 0);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
